// File: rtl/level_rom_map_if.sv
// Pixel lookup bus for level_rom_map: screen coordinate and room select in,
// combinational and registered wall flags out.
interface level_rom_map_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [2:0] room;
    logic       bg_type;
    logic       bg_type_q;

    modport master (output DrawX, DrawY, room, input bg_type, bg_type_q);
    modport slave  (input DrawX, DrawY, room, output bg_type, bg_type_q);
endinterface

// File: rtl/level_rom_map.sv
// Tile-map ROM: classifies a screen pixel as wall (1) or floor (0) for the
// selected room, with a combinational result and a registered copy.
module level_rom_map #(
    parameter int TILE_SHIFT = 5,
    parameter int MAP_COLS   = 20,
    parameter int MAP_ROWS   = 15
) (
    input  logic         Clk,
    input  logic         Reset,
    level_rom_map_if.slave bus
);
    localparam int TW = 10 - TILE_SHIFT;

    localparam logic [TW-1:0] LAST_COL = TW'(MAP_COLS - 1);
    localparam logic [TW-1:0] LAST_ROW = TW'(MAP_ROWS - 1);
    localparam logic [TW-1:0] DOOR_L   = TW'(MAP_COLS / 2 - 1);
    localparam logic [TW-1:0] DOOR_R   = TW'(MAP_COLS / 2);
    localparam logic [TW-1:0] OBS_C0   = TW'(4);
    localparam logic [TW-1:0] OBS_C1   = TW'(MAP_COLS - 5);
    localparam logic [TW-1:0] OBS_R0   = TW'(4);
    localparam logic [TW-1:0] OBS_R1   = TW'(10);

    localparam logic [9:0] X_LIMIT = 10'(MAP_COLS << TILE_SHIFT);
    localparam logic [9:0] Y_LIMIT = 10'(MAP_ROWS << TILE_SHIFT);

    logic [9:0]    col_full;
    logic [9:0]    row_full;
    logic [TW-1:0] col;
    logic [TW-1:0] row;
    logic          off_screen;
    logic          border;
    logic          door_col;
    logic          top_door;
    logic          bottom_door;
    logic          obstacle;
    logic          wall;

    always_comb begin
        col_full    = bus.DrawX >> TILE_SHIFT;
        row_full    = bus.DrawY >> TILE_SHIFT;
        col         = col_full[TW-1:0];
        row         = row_full[TW-1:0];
        off_screen  = (bus.DrawX >= X_LIMIT) || (bus.DrawY >= Y_LIMIT);
        border      = (col == '0) || (col == LAST_COL) ||
                      (row == '0) || (row == LAST_ROW);
        door_col    = (col == DOOR_L) || (col == DOOR_R);
        top_door    = (row == '0) && door_col && (bus.room != 3'd6);
        bottom_door = (row == LAST_ROW) && door_col && (bus.room != 3'd1);
        obstacle    = 1'b0;
        wall        = 1'b0;

        case (bus.room)
            3'd2: obstacle = ((col == OBS_C0) || (col == OBS_C1)) &&
                             ((row == OBS_R0) || (row == OBS_R1));
            3'd5: obstacle = door_col && (row >= OBS_R0) && (row <= OBS_R1);
            default: obstacle = 1'b0;
        endcase

        if (off_screen) begin
            wall = 1'b1;
        end else begin
            case (bus.room)
                3'd0:    wall = 1'b0;
                3'd7:    wall = 1'b1;
                // door gaps punch through the border ring
                default: wall = (border && !(top_door || bottom_door)) || obstacle;
            endcase
        end
    end

    assign bus.bg_type = wall;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bus.bg_type_q <= 1'b0;
        end else begin
            bus.bg_type_q <= wall;
        end
    end
endmodule

// File: tb/tb_level_rom_map.sv
// Self-checking bench for level_rom_map: directed lookups, spawn footprint sweep
// and the registered/async-reset path, checked through a scoreboard.
module tb_level_rom_map;
    logic clk;
    logic rst;

    level_rom_map_if bus ();

    level_rom_map dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assertions = 0;
    int failures   = 0;

    logic comb_sb[$];
    logic reg_sb[$];

    task automatic check(input string tag, input logic got, input logic exp);
        assertions++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive one lookup; combinational result checked at once, registered copy
    // checked after the following rising edge.
    task automatic apply(input int x, input int y, input int r, input logic exp,
                         input string tag);
        logic e;
        @(negedge clk);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        bus.room  = 3'(r);
        comb_sb.push_back(exp);
        reg_sb.push_back(exp);
        #1;
        e = comb_sb.pop_front();
        check({tag, " comb"}, bus.bg_type, e);
        @(posedge clk);
        #1;
        e = reg_sb.pop_front();
        check({tag, " reg"}, bus.bg_type_q, e);
    endtask

    int spawn_x[30] = '{300, 70, 100, 150, 200,
                        448, 128, 288, 384, 192,
                        480, 64, 448, 64, 512,
                        384, 448, 576, 128, 32,
                        416, 192, 64, 416, 192,
                        416, 192, 320, 544, 64};
    int spawn_y[30] = '{200, 330, 330, 330, 330,
                        160, 160, 224, 352, 352,
                        96, 64, 256, 288, 416,
                        160, 352, 416, 128, 416,
                        192, 192, 224, 288, 288,
                        128, 128, 256, 288, 288};

    initial begin
        rst       = 1'b1;
        bus.DrawX = '0;
        bus.DrawY = '0;
        bus.room  = 3'd1;
        #12;
        check("reset q", bus.bg_type_q, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        apply(0,   0,   1, 1'b1, "r1 corner");
        apply(300, 200, 1, 1'b0, "r1 spawn");
        apply(331, 231, 1, 1'b0, "r1 spawn far");
        apply(320, 0,   1, 1'b0, "r1 top door");
        apply(320, 470, 1, 1'b1, "r1 no bottom door");
        apply(128, 128, 2, 1'b1, "r2 obstacle");
        apply(127, 128, 2, 1'b0, "r2 left of obstacle");
        apply(160, 128, 2, 1'b0, "r2 right of obstacle");
        apply(288, 224, 2, 1'b0, "r2 spawn");
        apply(320, 470, 2, 1'b0, "r2 bottom door");
        apply(480, 320, 2, 1'b1, "r2 obstacle 15,10");
        apply(288, 128, 5, 1'b1, "r5 column top");
        apply(351, 351, 5, 1'b1, "r5 column bottom");
        apply(352, 200, 5, 1'b0, "r5 right of column");
        apply(300, 127, 5, 1'b0, "r5 above column");
        apply(300, 352, 5, 1'b0, "r5 below column");
        apply(320, 0,   6, 1'b1, "r6 no top door");
        apply(320, 479, 6, 1'b0, "r6 bottom door");
        apply(0,   0,   0, 1'b0, "r0 corner");
        apply(639, 479, 0, 1'b0, "r0 last pixel");
        apply(640, 0,   0, 1'b1, "r0 x offscreen");
        apply(0,   480, 0, 1'b1, "r0 y offscreen");
        apply(300, 200, 7, 1'b1, "r7 wall");
        apply(700, 700, 3, 1'b1, "offscreen any");
        apply(31,  100, 4, 1'b1, "x31 border");
        apply(32,  100, 4, 1'b0, "x32 interior");
        apply(608, 100, 4, 1'b1, "x608 col19");
        apply(100, 447, 4, 1'b0, "y447 row13");
        apply(100, 448, 4, 1'b1, "y448 row14");

        for (int i = 0; i < 30; i++) begin
            for (int c = 0; c < 4; c++) begin
                apply(spawn_x[i] + ((c & 1) != 0 ? 31 : 0),
                      spawn_y[i] + ((c & 2) != 0 ? 31 : 0),
                      i / 5 + 1, 1'b0,
                      $sformatf("spawn r%0d #%0d c%0d", i / 5 + 1, i % 5, c));
            end
        end

        // Registered path with an asynchronous reset pulse
        apply(0, 0, 1, 1'b1, "reg pre-reset");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async reset q", bus.bg_type_q, 1'b0);
        @(posedge clk);
        #1;
        check("reset hold q", bus.bg_type_q, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after release q", bus.bg_type_q, 1'b0);
        @(posedge clk);
        #1;
        check("resume q", bus.bg_type_q, 1'b1);
        @(negedge clk);
        bus.DrawX = 10'd300;
        bus.DrawY = 10'd200;
        #1;
        check("move comb", bus.bg_type, 1'b0);
        check("move q old", bus.bg_type_q, 1'b1);
        @(posedge clk);
        #1;
        check("move q new", bus.bg_type_q, 1'b0);
        @(negedge clk);
        bus.room = 3'd7;
        #1;
        check("room change comb", bus.bg_type, 1'b1);
        check("room change q old", bus.bg_type_q, 1'b0);
        @(posedge clk);
        #1;
        check("room change q new", bus.bg_type_q, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions, failures);
        $finish;
    end
endmodule

// File: doc/level_rom_map.md
Name: level_rom_map

Overview:
- Tile-map ROM that classifies any screen pixel as wall (1) or floor (0) for the currently selected dungeon room.
- Used by the player, enemy and renderer blocks for collision tests and background selection.
- Primary lookup is purely combinational, so callers can test candidate positions in the same cycle.
- A registered copy of the result is also provided for pipelined VGA drawing.

Parameters:
- TILE_SHIFT, 5, log2 of tile edge in pixels (32x32 tiles).
- MAP_COLS, 20, tiles per row (640 px screen).
- MAP_ROWS, 15, tile rows (480 px screen).

Ports:
- Clk  input  1  system clock; the only clock.
- Reset  input  1  asynchronous, active-high reset; clears the registered output only.
- DrawX  input  10  pixel X coordinate, unsigned.
- DrawY  input  10  pixel Y coordinate, unsigned.
- room  input  3  room select 0..7.
- bg_type  output  1  combinational wall flag: 1 = wall, 0 = floor.
- bg_type_q  output  1  bg_type registered on rising Clk edge.

Behaviour:
- Tile address: col = DrawX >> 5, row = DrawY >> 5.
- Off-screen pixels: if DrawX >= 640 or DrawY >= 480, bg_type = 1 for every room.
- bg_type is a pure function of (DrawX, DrawY, room).
  - No latency, no state.
  - Independent of Clk and Reset.
- bg_type_q latches bg_type on every rising edge of Clk (1-cycle latency).
  - Async Reset forces bg_type_q = 0 immediately and holds it while Reset is high.
  - Resumes sampling on the first edge after Reset falls.
- room 0 (title/empty): every on-screen tile is floor (0).
- room 7 (unused): every tile is wall (1).
- Rooms 1..6, border walls: col 0, col 19, row 0 and row 14 are wall.
- Rooms 1..6, door gaps: the gaps below override the border and are floor.
  - Top door: row 0, cols 9-10. Present in rooms 1-5, absent in room 6.
  - Bottom door: row 14, cols 9-10. Present in rooms 2-6, absent in room 1.
- Interior obstacles (all other interior tiles are floor):
  - room 2: single wall tiles at (col,row) (4,4), (15,4), (4,10), (15,10).
  - room 5: wall column at cols 9-10, rows 4-10 inclusive.
  - rooms 1, 3, 4, 6: no interior obstacles.
- Requirement: every enemy spawn tile and its 32x32 footprint is floor. The spawn list, as (x,y):
  - room 1: (300,200), (70,330), (100,330), (150,330), (200,330).
  - room 2: (448,160), (128,160), (288,224), (384,352), (192,352).
  - room 3: (480,96), (64,64), (448,256), (64,288), (512,416).
  - room 4: (384,160), (448,352), (576,416), (128,128), (32,416).
  - room 5: (416,192), (192,192), (64,224), (416,288), (192,288).
  - room 6: (416,128), (192,128), (320,256), (544,288), (64,288).
- Boundaries:
  - Pixel 31 and pixel 32 fall in different tiles.
  - X=639 is col 19; X=640 is off-screen (wall).
  - Y=479 is row 14; Y=480 is off-screen (wall).
- A room change takes effect on bg_type immediately and on bg_type_q at the next edge.
- Multiple instances may be driven with different coordinates concurrently; the block has no shared state.

Test Plan:
- room=1, (DrawX,DrawY)=(0,0) -> bg_type=1; (300,200) -> 0; (331,231) -> 0; (320,0) (col 10, top door) -> 0; (320,470) -> 1.
- room=2: (128,128) -> 1; (127,128) -> 0; (160,128) -> 0; (288,224) -> 0; (320,470) -> 0.
- room=5: (288,128) -> 1; (351,351) -> 1; (352,200) -> 0; (300,127) -> 0. room=6: (320,0) -> 1; (320,479) -> 0.
- room=0: (0,0) -> 0; (639,479) -> 0; (640,0) -> 1. room=7: (300,200) -> 1. Any room: (700,700) -> 1.
- Sweep all 30 spawn points x 4 corners (x, x+31, y, y+31) -> every result 0.
- Registered path:
  - Drive (0,0), room 1, then clock -> bg_type_q=1.
  - Assert Reset asynchronously mid-cycle -> bg_type_q=0 without a clock edge.
  - Deassert Reset, then one edge -> bg_type_q=1.
  - Change to (300,200) -> bg_type=0 at once, bg_type_q=0 after the next edge.
